// File: rtl/bcd_write_encoder.sv
// rtl/bcd_write_encoder.sv - sequential binary to packed BCD encoder for the RTC write path
module bcd_write_encoder #(
    parameter int N_CH     = 9,
    parameter int IN_W     = 7,
    parameter int DIGITS   = 2,
    parameter int AMPM_CH  = 0,
    parameter int HOUR_MAX = 12
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_CH*IN_W-1:0]   ch_data,
    input  logic [N_CH-1:0]        sel,
    input  logic                   am_pm,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [4*DIGITS-1:0]    dato_BCD
);

    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(IN_W + 1);
    localparam int IDXW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [31:0]     HOUR_LIM = 32'(HOUR_MAX);
    localparam logic [31:0]     DEC_LIM  = 32'(10 ** DIGITS - 1);
    localparam logic [IDXW-1:0] AMPM_IDX = IDXW'(AMPM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IN_W-1:0] raw_q;
    logic [IN_W-1:0] sh_q;
    logic [IDXW-1:0] idx_q;
    logic            ampm_q;
    logic [BW-1:0]   bcd_q;
    logic [CW-1:0]   cnt_q;

    logic [IDXW-1:0] pick_idx;
    logic [IN_W-1:0] pick_val;
    logic [BW-1:0]   bcd_adj;
    logic            legal;
    logic [BW-1:0]   result;
    logic            accept;

    // Scan from the top so the lowest set select bit is the one that sticks
    always_comb begin
        pick_idx = '0;
        pick_val = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                pick_idx = IDXW'(i);
                pick_val = ch_data[i*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Range check on the full binary value; BCD carry out of the top digit is never seen
    always_comb begin
        if (idx_q == AMPM_IDX) begin
            legal = 32'(raw_q) <= HOUR_LIM;
        end else begin
            legal = 32'(raw_q) <= DEC_LIM;
        end
        result = '0;
        if (legal) begin
            result = bcd_q;
            if (idx_q == AMPM_IDX) begin
                result[BW-1] = ampm_q;
            end
        end
    end

    assign accept = (state_q == IDLE) && start && (|sel);
    assign busy   = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q    <= '0;
            sh_q     <= '0;
            idx_q    <= '0;
            ampm_q   <= 1'b0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dato_BCD <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        raw_q  <= pick_val;
                        sh_q   <= pick_val;
                        idx_q  <= pick_idx;
                        ampm_q <= am_pm;
                        bcd_q  <= '0;
                        cnt_q  <= CW'(IN_W);
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BW-2:0], sh_q[IN_W-1]};
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q - CW'(1);
                end
                FIN: begin
                    dato_BCD <= result;
                    ovf      <= ~legal;
                    done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
